// File: rtl/ask_mer_meter.sv
// N-channel 4-ASK slicer with windowed reference-level, MSE and DC-error measurement.
// Optional feature macro: MER_DC_EN builds the DC-error accumulators; otherwise dc_out is tied to 0.
module ask_mer_meter #(
  parameter int WIDTH    = 18,
  parameter int NUM_CH   = 2,
  parameter int WIN_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_clk_en,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [NUM_CH*WIDTH-1:0]  dec_var,
  output logic [NUM_CH*WIDTH-1:0]  ref_level,
  output logic [NUM_CH*2-1:0]      sym_out,
  output logic [NUM_CH*WIDTH-1:0]  err_out,
  output logic [NUM_CH*WIDTH-1:0]  mse_out,
  output logic [NUM_CH*WIDTH-1:0]  dc_out,
  output logic                     result_valid,
  output logic                     busy
);

  localparam int EW  = WIDTH + 2;
  localparam int SQW = WIDTH + WIN_LOG2;
  localparam int AW  = WIDTH + WIN_LOG2 + 1;
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_MEAS, S_RESULT} state_t;

  state_t              state_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic                result_valid_q;
  logic                busy_q;

  logic acq_clr, acq_en, acq_done, meas_en, meas_done;

  // Window-boundary strobes shared by every channel's accumulators.
  always_comb begin
    acq_clr   = ((state_q == S_IDLE) && start) || ((state_q == S_RESULT) && continuous);
    acq_en    = (state_q == S_ACQ) && sym_clk_en;
    acq_done  = acq_en && (cnt_q == '1);
    meas_en   = (state_q == S_MEAS) && sym_clk_en;
    meas_done = meas_en && (cnt_q == '1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ACQ;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_ACQ: begin
          if (sym_clk_en) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) state_q <= S_MEAS;
          end
        end
        S_MEAS: begin
          if (sym_clk_en) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
              state_q        <= S_RESULT;
              result_valid_q <= 1'b1;
            end
          end
        end
        S_RESULT: begin
          cnt_q <= '0;
          if (continuous) begin
            state_q <= S_ACQ;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid = result_valid_q;
  assign busy         = busy_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic signed [WIDTH-1:0]   x, ref_q, ref_d, err_sat, err_q, mse_q, mse_d;
    logic [1:0]                sym_d, sym_q;
    logic signed [EW-1:0]      x_e, a_e, two_a, three_a, ideal, err_full, abs_e;
    logic signed [2*WIDTH-1:0] err_w, sq_full;
    logic [WIDTH-1:0]          sq_keep;
    logic signed [AW-1:0]      abs_acc_q, abs_sum;
    logic [SQW-1:0]            sq_acc_q, sq_sum, sq_mean;

    always_comb begin
      x        = dec_var[gi*WIDTH +: WIDTH];
      x_e      = EW'(x);
      a_e      = EW'(ref_q);
      two_a    = a_e <<< 1;
      three_a  = a_e + two_a;
      sym_d    = 2'b00;
      ideal    = -three_a;
      // Decision thresholds at 0 and +-2a; equality falls to the upper level.
      if (x_e >= two_a) begin
        sym_d = 2'b10;
        ideal = three_a;
      end else if (!x_e[EW-1]) begin
        sym_d = 2'b11;
        ideal = a_e;
      end else if (x_e >= -two_a) begin
        sym_d = 2'b01;
        ideal = -a_e;
      end
      err_full = x_e - ideal;
      if (err_full > EW'(SMAX))      err_sat = SMAX;
      else if (err_full < EW'(SMIN)) err_sat = SMIN;
      else                           err_sat = err_full[WIDTH-1:0];

      abs_e   = x_e[EW-1] ? -x_e : x_e;
      abs_sum = abs_acc_q + AW'(abs_e);
      ref_d   = WIDTH'(abs_sum >>> (WIN_LOG2 + 1));

      err_w   = (2*WIDTH)'(err_sat);
      sq_full = err_w * err_w;
      sq_keep = sq_full[2*WIDTH-2 -: WIDTH];
      sq_sum  = sq_acc_q + SQW'(sq_keep);
      sq_mean = sq_sum >> WIN_LOG2;
      if (sq_mean > SQW'($unsigned(SMAX))) mse_d = SMAX;
      else                                  mse_d = sq_mean[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        sym_q     <= '0;
        err_q     <= '0;
        ref_q     <= '0;
        mse_q     <= '0;
        abs_acc_q <= '0;
        sq_acc_q  <= '0;
      end else begin
        if (sym_clk_en) begin
          sym_q <= sym_d;
          err_q <= err_sat;
        end
        if (acq_clr)     abs_acc_q <= '0;
        else if (acq_en) abs_acc_q <= abs_sum;
        if (acq_done) begin
          ref_q    <= ref_d;
          sq_acc_q <= '0;
        end else if (meas_en) begin
          sq_acc_q <= sq_sum;
        end
        if (meas_done) mse_q <= mse_d;
      end
    end

    assign sym_out[gi*2 +: 2]         = sym_q;
    assign err_out[gi*WIDTH +: WIDTH]   = err_q;
    assign ref_level[gi*WIDTH +: WIDTH] = ref_q;
    assign mse_out[gi*WIDTH +: WIDTH]   = mse_q;

`ifdef MER_DC_EN
    logic signed [AW-1:0]    err_acc_q, err_sum, err_mean;
    logic signed [WIDTH-1:0] dc_q, dc_d;

    always_comb begin
      err_sum  = err_acc_q + AW'(err_sat);
      err_mean = err_sum >>> WIN_LOG2;
      if (err_mean > AW'(SMAX))      dc_d = SMAX;
      else if (err_mean < AW'(SMIN)) dc_d = SMIN;
      else                           dc_d = err_mean[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        err_acc_q <= '0;
        dc_q      <= '0;
      end else begin
        if (acq_done)     err_acc_q <= '0;
        else if (meas_en) err_acc_q <= err_sum;
        if (meas_done) dc_q <= dc_d;
      end
    end

    assign dc_out[gi*WIDTH +: WIDTH] = dc_q;
`else
    assign dc_out[gi*WIDTH +: WIDTH] = '0;
`endif
  end

endmodule
